// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with a pixel-enable,
// fetch coordinates, and a PIPE_LAT-deep aligned sync/DE/RGB delay line.
module vga_timing_gen #(
  parameter int HPIXELS  = 640,
  parameter int HFP      = 16,
  parameter int HSPULSE  = 96,
  parameter int HBP      = 48,
  parameter int VPIXELS  = 480,
  parameter int VFP      = 10,
  parameter int VSPULSE  = 2,
  parameter int VBP      = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 1,
  parameter int IN_RW    = 3,
  parameter int IN_GW    = 3,
  parameter int IN_BW    = 2,
  parameter int OUT_W    = 4,
  parameter int FCW      = 16
) (
  input  logic             vgaclk,
  input  logic             rst,
  input  logic             pix_ce,
  input  logic [IN_RW-1:0] input_red,
  input  logic [IN_GW-1:0] input_green,
  input  logic [IN_BW-1:0] input_blue,
  output logic [9:0]       hc_out,
  output logic [9:0]       vc_out,
  output logic             fetch_active,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [OUT_W-1:0] red,
  output logic [OUT_W-1:0] green,
  output logic [OUT_W-1:0] blue,
  output logic             line_start,
  output logic             frame_start,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int HTOTAL = HPIXELS + HFP + HSPULSE + HBP;
  localparam int VTOTAL = VPIXELS + VFP + VSPULSE + VBP;

  localparam logic [10:0] H_ACT  = 11'(HPIXELS);
  localparam logic [10:0] HS_ON  = 11'(HPIXELS + HFP);
  localparam logic [10:0] HS_OFF = 11'(HPIXELS + HFP + HSPULSE);
  localparam logic [10:0] V_ACT  = 11'(VPIXELS);
  localparam logic [10:0] VS_ON  = 11'(VPIXELS + VFP);
  localparam logic [10:0] VS_OFF = 11'(VPIXELS + VFP + VSPULSE);
  localparam logic [9:0]  H_LAST = 10'(HTOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);

  if (HTOTAL > 1024 || VTOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: HTOTAL/VTOTAL exceed 1024");
  end
  if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_lat
    $error("vga_timing_gen: PIPE_LAT outside 1..8");
  end
  if (IN_RW < 1 || IN_RW > OUT_W ||
      IN_GW < 1 || IN_GW > OUT_W ||
      IN_BW < 1 || IN_BW > OUT_W) begin : g_bad_w
    $error("vga_timing_gen: input colour width out of range");
  end

  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);
  assign hc_out = hc;
  assign vc_out = vc;

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      hc          <= '0;
      vc          <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      line_start  <= pix_ce & h_wrap;
      frame_start <= pix_ce & h_wrap & v_wrap;
      if (pix_ce) begin
        hc <= h_wrap ? '0 : hc + 10'd1;
        if (h_wrap) begin
          vc <= v_wrap ? '0 : vc + 10'd1;
          if (v_wrap) frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end

  logic act;
  logic hs_a;
  logic vs_a;

  always_comb begin
    act  = ({1'b0, hc} < H_ACT) && ({1'b0, vc} < V_ACT);
    hs_a = ({1'b0, hc} >= HS_ON) && ({1'b0, hc} < HS_OFF);
    vs_a = ({1'b0, vc} >= VS_ON) && ({1'b0, vc} < VS_OFF);
  end

  assign fetch_active = act;

  // tap[0] is the live stage; tap[k] is k pixel advances old.
  logic [PIPE_LAT-1:0][2:0] dly;
  logic [PIPE_LAT:0][2:0]   tap;

  assign tap = {dly, act, hs_a, vs_a};

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      dly <= '0;
    end else if (pix_ce) begin
      dly <= tap[PIPE_LAT-1:0];
    end
  end

  assign de    = tap[PIPE_LAT][2];
  assign hsync = tap[PIPE_LAT][1] ? HS_POL : ~HS_POL;
  assign vsync = tap[PIPE_LAT][0] ? VS_POL : ~VS_POL;

  logic [OUT_W-1:0] exp_r;
  logic [OUT_W-1:0] exp_g;
  logic [OUT_W-1:0] exp_b;

  // MSB replication: the input pattern repeats down to the LSB.
  for (genvar i = 0; i < OUT_W; i++) begin : g_exp
    assign exp_r[OUT_W-1-i] = input_red[IN_RW-1-(i % IN_RW)];
    assign exp_g[OUT_W-1-i] = input_green[IN_GW-1-(i % IN_GW)];
    assign exp_b[OUT_W-1-i] = input_blue[IN_BW-1-(i % IN_BW)];
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_ce) begin
      if (tap[PIPE_LAT-1][2]) begin
        red   <= exp_r;
        green <= exp_g;
        blue  <= exp_b;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule
